// File: rtl/uart_rx_engine.sv
// Oversampling UART receive engine: 8N1 framing, or 8E1 when UART_RX_PARITY_EN is defined.
// Delivers each good byte on data_o with a one-cycle rx_data_rdy_o strobe; flags are sticky per frame.
module uart_rx_engine #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_data_rdy_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | half a bit into the start bit, confirm it is still low
  // DATA   | sampling 8 data bits at their mid-points, LSB first
  // PARITY | sampling the even-parity bit (parity builds only)
  // STOP   | sampling the stop bit, deliver or flag a framing error
  // BREAK  | line held low after a bad stop, wait for it to return high
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t state, state_n;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          rdy_q;
  logic          ferr_q;
  logic          tick;
  logic          samp_done;
  logic          clr_cnt;
  logic          start_ok;
  logic          shift_en;
  logic          deliver;
  logic          set_ferr;
`ifdef UART_RX_PARITY_EN
  logic          par_cap;
  logic          par_rec_q;
  logic          perr_q;
`endif

  assign rx_s      = sync_q[1];
  assign tick      = (tick_cnt == TICK_LAST);
  // START samples after half a bit; every other state samples after a full bit
  assign samp_done = tick && (samp_cnt == ((state == S_START) ? SAMP_HALF : SAMP_LAST));

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr_cnt  = 1'b0;
    start_ok = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          clr_cnt = 1'b1;
        end
      end
      S_START: begin
        if (samp_done) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n  = S_DATA;
            start_ok = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (samp_done) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (samp_done) begin
          par_cap = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (samp_done) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_n = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= 2'b11;
      tick_cnt <= '0;
      samp_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};

      if (clr_cnt || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 1'b1;

      if (clr_cnt || samp_done) samp_cnt <= '0;
      else if (tick)            samp_cnt <= samp_cnt + 1'b1;

      if (start_ok)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;

      // right shift leaves the first-received bit in bit 0 after eight samples
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};

      if (deliver) data_q <= shift_q;
      rdy_q <= deliver;

      if (start_ok)      ferr_q <= 1'b0;
      else if (set_ferr) ferr_q <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      par_rec_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (par_cap) par_rec_q <= ^{shift_q, rx_s};
      if (start_ok)     perr_q <= 1'b0;
      else if (deliver) perr_q <= par_rec_q;
    end
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o        = data_q;
  assign rx_data_rdy_o = rdy_q;
  assign busy_o        = (state != S_IDLE);
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: table of frames plus hand sequences for glitch,
// break, back-to-back and mid-frame reset; a scoreboard checks every delivered byte.
module tb_uart_rx_engine;

  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int LAT   = PAR_ON ? 1683 : 1523;
  localparam int FRAME = (PAR_ON ? 11 : 10) * BIT;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rx;
  logic [7:0] data_o;
  logic       rx_data_rdy_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       parity_err_o;

  uart_rx_engine #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rx_i         (rx),
    .data_o       (data_o),
    .rx_data_rdy_o(rx_data_rdy_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         fall;
  } exp_t;
  exp_t sb[$];

  int strobe_cnt = 0;
  int strobe_cyc[$];
  logic prev_rdy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rx_data_rdy_o) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      chk("strobe_width", int'(prev_rdy), 0);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_strobe: data_o=0x%0h with nothing expected at cycle %0d", data_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("rx_data", int'(data_o), int'(e.data));
        chk("rx_parity_err", int'(parity_err_o), int'(e.perr));
        chk("rx_frame_err", int'(frame_err_o), 0);
        chk("rx_latency", cyc - e.fall, LAT);
      end
    end
    prev_rdy = rx_data_rdy_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip,
                            input logic exp_rdy);
    exp_t e;
    if (exp_rdy) begin
      e.data = d;
      e.perr = PAR_ON ? flip : 1'b0;
      e.fall = cyc;
      sb.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_ON) drive_bit(^d ^ flip);
    drive_bit(stop_b);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       par_flip;
    logic       exp_rdy;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n0;
    int f0;
    int fell;
    int low_busy;
    logic seen_hi;
    logic [7:0] d0;
    logic [7:0] dr;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h6E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rx      = 1'b1;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", int'(data_o), 0);
    chk("reset_rdy", int'(rx_data_rdy_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_ferr", int'(frame_err_o), 0);
    chk("reset_perr", int'(parity_err_o), 0);
    reset_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      n0 = strobe_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, vecs[i].exp_rdy);
      chk("row_strobes", strobe_cnt - n0, vecs[i].exp_rdy ? 1 : 0);
      chk("row_ferr", int'(frame_err_o), int'(vecs[i].exp_ferr));
      chk("row_perr", int'(parity_err_o), PAR_ON ? int'(vecs[i].exp_perr) : 0);
      chk("row_busy_after_stop", int'(busy_o), vecs[i].stop_bit ? 0 : 1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("row_busy_idle", int'(busy_o), 0);
    end

    // glitch: 40 low cycles must be rejected at the start-bit check
    n0 = strobe_cnt;
    d0 = data_o;
    seen_hi = 1'b0;
    fell = -1;
    rx = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 40) rx = 1'b1;
      if (busy_o) seen_hi = 1'b1;
      else if (seen_hi && fell < 0) fell = k;
    end
    chk("glitch_busy_seen", int'(seen_hi), 1);
    chk("glitch_busy_fall_in_85", (fell > 0 && fell <= 85) ? 1 : 0, 1);
    chk("glitch_no_strobe", strobe_cnt - n0, 0);
    chk("glitch_data_kept", int'(data_o), int'(d0));

    // framing error followed by a long break
    n0 = strobe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("break_ferr_set", int'(frame_err_o), 1);
    low_busy = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      if (!busy_o) low_busy++;
    end
    chk("break_busy_held", low_busy, 0);
    chk("break_no_strobe", strobe_cnt - n0, 0);
    chk("break_data_kept", int'(data_o), int'(d0));
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("break_busy_released", int'(busy_o), 0);
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      begin
        repeat (82) @(posedge clk);
        #1;
        chk("ferr_held_before_validate", int'(frame_err_o), 1);
        @(posedge clk);
        #1;
        chk("ferr_cleared_at_validate", int'(frame_err_o), 0);
      end
    join
    chk("after_break_data", int'(data_o), 8'h55);
    drive_bit(1'b1);

    // back-to-back frames, no idle gap
    n0 = strobe_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    chk("b2b_strobes", strobe_cnt - n0, 3);
    if (strobe_cnt - n0 == 3) begin
      chk("b2b_gap_1", strobe_cyc[n0 + 1] - strobe_cyc[n0], FRAME);
      chk("b2b_gap_2", strobe_cyc[n0 + 2] - strobe_cyc[n0 + 1], FRAME);
    end
    drive_bit(1'b1);

    // reset during data bit 4 of 0x12; the transmitter abandons the frame too
    n0 = strobe_cnt;
    dr = 8'h12;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(dr[i]);
    rx = dr[4];
    repeat (80) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("midrst_data", int'(data_o), 0);
    chk("midrst_rdy", int'(rx_data_rdy_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_ferr", int'(frame_err_o), 0);
    chk("midrst_perr", int'(parity_err_o), 0);
    rx = 1'b1;
    repeat (1800) @(posedge clk);
    #1;
    chk("midrst_no_strobe", strobe_cnt - n0, 0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b1);
    chk("after_reset_data", int'(data_o), 8'h34);
    drive_bit(1'b1);

    f0 = int'(sb.size());
    chk("scoreboard_drained", f0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
